// File: rtl/wisc_pkg.sv
// Shared definitions for the EX result stage: widths, opcodes, flag indices,
// skid-buffer occupancy encoding and the buffered entry layout.
package wisc_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 4;
  localparam int unsigned RW  = 4;

  localparam logic [OPW-1:0] OP_ADD  = 4'h0;
  localparam logic [OPW-1:0] OP_SUB  = 4'h1;
  localparam logic [OPW-1:0] OP_AND  = 4'h2;
  localparam logic [OPW-1:0] OP_OR   = 4'h3;
  localparam logic [OPW-1:0] OP_XOR  = 4'h4;
  localparam logic [OPW-1:0] OP_SLL  = 4'h5;
  localparam logic [OPW-1:0] OP_SRA  = 4'h6;
  localparam logic [OPW-1:0] OP_ROR  = 4'h7;
  localparam logic [OPW-1:0] OP_LW   = 4'h8;
  localparam logic [OPW-1:0] OP_SW   = 4'h9;
  localparam logic [OPW-1:0] OP_LHB  = 4'hA;
  localparam logic [OPW-1:0] OP_LLB  = 4'hB;
  localparam logic [OPW-1:0] OP_B    = 4'hC;
  localparam logic [OPW-1:0] OP_BR   = 4'hD;
  localparam logic [OPW-1:0] OP_PCS  = 4'hE;
  localparam logic [OPW-1:0] OP_HLT  = 4'hF;

  localparam logic [1:0] FLAG_Z = 2'd2;
  localparam logic [1:0] FLAG_V = 2'd1;
  localparam logic [1:0] FLAG_N = 2'd0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [DW-1:0]  result;
    logic           cout;
    logic           ovf;
    logic [OPW-1:0] op;
    logic [RW-1:0]  rd;
  } alu_entry_t;

  localparam int unsigned ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry FIFO skid buffer with registered valid/ready on both sides and flush.
module pipe_skid_buf
  import wisc_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_state_t  state, state_nxt;
  logic [W-1:0] tail;
  logic        accept, retire;
  logic        head_load, head_from_tail, tail_load;

  assign accept = in_valid && in_ready;
  assign retire = out_valid && out_ready;

  // Occupancy transitions; flush wins and suppresses any same-cycle capture.
  always_comb begin
    state_nxt      = state;
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (accept) begin
          state_nxt = OCC_ONE;
          head_load = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept && retire) begin
          head_load = 1'b1;
        end else if (accept) begin
          state_nxt = OCC_FULL;
          tail_load = 1'b1;
        end else if (retire) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (retire) begin
          state_nxt      = OCC_ONE;
          head_from_tail = 1'b1;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
    if (flush) begin
      state_nxt      = OCC_EMPTY;
      head_load      = 1'b0;
      head_from_tail = 1'b0;
      tail_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OCC_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      tail      <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != OCC_FULL);
      out_valid <= (state_nxt != OCC_EMPTY);
      if (head_load) begin
        out_data <= in_data;
      end else if (head_from_tail) begin
        out_data <= tail;
      end
      if (tail_load) begin
        tail <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// EX result stage: buffers ALU results toward MEM and owns the Z/V/N flag register,
// which changes only when an entry retires at the output handshake.
module alu_result_stage
  import wisc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_result,
  input  logic           in_cout,
  input  logic           in_ovf,
  input  logic [OPW-1:0] in_op,
  input  logic [RW-1:0]  in_rd,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_result,
  output logic [OPW-1:0] out_op,
  output logic [RW-1:0]  out_rd,
  output logic [2:0]     flags
);

  alu_entry_t in_entry;
  alu_entry_t head;
  logic       retire;
  logic [2:0] flags_nxt;
  logic       unused_cout;

  assign in_entry = {in_result, in_cout, in_ovf, in_op, in_rd};

  pipe_skid_buf #(
    .W(ENTRY_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  assign out_result = head.result;
  assign out_op     = head.op;
  assign out_rd     = head.rd;
  // Carry travels with the entry but is reserved; no flag consumes it yet.
  assign unused_cout = head.cout;

  assign retire = out_valid && out_ready;

  // Flag decode from the retiring head entry.
  always_comb begin
    flags_nxt = flags;
    if (retire) begin
      case (head.op)
        OP_ADD, OP_SUB: begin
          flags_nxt[FLAG_Z] = (head.result == '0);
          flags_nxt[FLAG_V] = head.ovf;
          flags_nxt[FLAG_N] = head.result[DW-1];
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
          flags_nxt[FLAG_Z] = (head.result == '0);
        end
        default: flags_nxt = flags;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else begin
      flags <= flags_nxt;
    end
  end

endmodule
